// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller:
// state encoding, ALU ops, instruction field codes and datapath select values.
package mc_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Unsupported data-processing commands fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    logic [1:0] op;
    case (cmd)
      CMD_ADD: op = ALU_ADD;
      CMD_SUB: op = ALU_SUB;
      CMD_AND: op = ALU_AND;
      CMD_ORR: op = ALU_ORR;
      CMD_CMP: op = ALU_SUB;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Combinational ARM condition evaluator: stored NZCV flags and the Cond field
// produce CondEx. Condition 1111 never executes.
module cond_check
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: FSM sequencing FETCH..WB, datapath select decode,
// NZCV flag register and condition-gated architectural write enables.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter logic [3:0] PC_IDX  = 4'd15,
  parameter int         STATE_W = 4
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         Cond,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUControl,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] StateDbg
);

  state_t     state, next_state;
  logic [3:0] flags;
  logic       cond_ex;
  logic [3:0] cmd;
  logic       is_cmp, rd_is_pc, in_exec;
  logic       pc_write_en, mem_write_en, ir_write_en, reg_write_en;

  assign cmd      = Funct[4:1];
  assign is_cmp   = (cmd == CMD_CMP);
  assign rd_is_pc = (Rd == PC_IDX);
  assign in_exec  = (state == S_EXECR) || (state == S_EXECI);
  assign StateDbg = STATE_W'(state);

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Carry and overflow only carry meaning for the arithmetic commands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if (in_exec && cond_ex && (Funct[0] || is_cmp)) begin
      flags[3:2] <= ALUFlags[3:2];
      if (cmd == CMD_ADD || cmd == CMD_SUB || is_cmp)
        flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  next_state = S_MEMADR;
          OP_BR:   next_state = S_BRANCH;
          OP_DP:   next_state = Funct[5] ? S_EXECI : S_EXECR;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXECR:  next_state = S_ALUWB;
      S_EXECI:  next_state = S_ALUWB;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_en  = 1'b0;
    mem_write_en = 1'b0;
    ir_write_en  = 1'b0;
    reg_write_en = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUControl   = ALU_ADD;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REG;
    case (state)
      S_FETCH: begin
        ir_write_en = 1'b1;
        pc_write_en = 1'b1;
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWR: begin
        AdrSrc       = 1'b1;
        mem_write_en = cond_ex;
      end
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        reg_write_en = cond_ex;
        pc_write_en  = cond_ex & rd_is_pc;
      end
      S_EXECR: ALUControl = alu_decode(cmd);
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_decode(cmd);
      end
      S_ALUWB: begin
        ResultSrc    = RES_ALUOUT;
        reg_write_en = cond_ex & ~is_cmp;
        pc_write_en  = cond_ex & rd_is_pc;
      end
      S_BRANCH: begin
        ALUSrcB     = SRCB_IMM;
        ResultSrc   = RES_ALU;
        pc_write_en = cond_ex;
      end
      default: ;
    endcase
  end

  // Immediate format and register-read routing depend only on the instruction class.
  always_comb begin
    ImmSrc = IMM_DP;
    case (Op)
      OP_MEM:  ImmSrc = IMM_MEM;
      OP_BR:   ImmSrc = IMM_BR;
      default: ImmSrc = IMM_DP;
    endcase
  end

  assign RegSrc = {Op == OP_MEM, Op == OP_BR};

  // Reset overrides every enable combinationally so nothing pulses while it is low.
  assign PCWrite  = pc_write_en  & reset;
  assign MemWrite = mem_write_en & reset;
  assign IRWrite  = ir_write_en  & reset;
  assign RegWrite = reg_write_en & reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed ARM instruction
// scenarios plus random instructions against an instruction-level model.
module tb_multicycle_controller;

  localparam int FETCH  = 0;
  localparam int DECODE = 1;
  localparam int MEMADR = 2;
  localparam int MEMRD  = 3;
  localparam int MEMWB  = 4;
  localparam int MEMWR  = 5;
  localparam int EXECR  = 6;
  localparam int EXECI  = 7;
  localparam int ALUWB  = 8;
  localparam int BRANCH = 9;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] alc;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] imm;
    logic [1:0] rgs;
    logic       rw;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0] StateDbg;
  ctl_t       act;

  int         compared   = 0;
  int         mismatched = 0;
  logic [3:0] mflags;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .StateDbg   (StateDbg)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite};

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic string stateName(input int st);
    case (st)
      FETCH:   return "FETCH";
      DECODE:  return "DECODE";
      MEMADR:  return "MEMADR";
      MEMRD:   return "MEMRD";
      MEMWB:   return "MEMWB";
      MEMWR:   return "MEMWR";
      EXECR:   return "EXECR";
      EXECI:   return "EXECI";
      ALUWB:   return "ALUWB";
      default: return "BRANCH";
    endcase
  endfunction

  // Conditions come in complementary pairs: even code = base test, odd = its inverse.
  function automatic logic modelCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~r : r;
  endfunction

  function automatic logic [1:0] modelAlu(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      4'b1010: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic buildExp(input int st, input logic ce, input logic [5:0] funct,
                          input logic [3:0] rd, input bit inReset,
                          output ctl_t e, output ctl_t m);
    e = '0;
    m = '0;
    m.pcw = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.rw = 1'b1;
    case (st)
      FETCH: begin
        e.irw = 1'b1; e.pcw = 1'b1; e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10;
        m.adr = 1'b1; m.asa = 1'b1; m.asb = 2'b11; m.alc = 2'b11; m.rs = 2'b11;
      end
      DECODE: begin
        e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10;
        m.asa = 1'b1; m.asb = 2'b11; m.alc = 2'b11; m.rs = 2'b11;
      end
      MEMADR: begin
        e.asb = 2'b01; e.alc = funct[3] ? 2'b00 : 2'b01; e.imm = 2'b01;
        m.asa = 1'b1; m.asb = 2'b11; m.alc = 2'b11; m.imm = 2'b11;
      end
      MEMRD: begin
        e.adr = 1'b1; m.adr = 1'b1;
      end
      MEMWR: begin
        e.adr = 1'b1; e.mw = ce; e.rgs = 2'b10;
        m.adr = 1'b1; m.rgs = 2'b10;
      end
      MEMWB: begin
        e.rs = 2'b01; e.rw = ce; e.pcw = ce & (rd == 4'd15);
        m.rs = 2'b11;
      end
      EXECR, EXECI: begin
        e.asb = (st == EXECI) ? 2'b01 : 2'b00;
        e.alc = modelAlu(funct[4:1]);
        m.asa = 1'b1; m.asb = 2'b11; m.alc = 2'b11;
        if (st == EXECI) m.imm = 2'b11;
      end
      ALUWB: begin
        e.rw = ce & (funct[4:1] != 4'b1010); e.pcw = ce & (rd == 4'd15);
        m.rs = 2'b11;
      end
      default: begin
        e.rgs = 2'b01; e.asb = 2'b01; e.imm = 2'b10; e.rs = 2'b10; e.pcw = ce;
        m.asa = 1'b1; m.rgs = 2'b01; m.asb = 2'b11; m.imm = 2'b11; m.alc = 2'b11; m.rs = 2'b11;
      end
    endcase
    if (inReset) begin
      e.pcw = 1'b0; e.mw = 1'b0; e.irw = 1'b0; e.rw = 1'b0;
    end
  endtask

  // Entered between a rising and falling edge with the DUT in FETCH.
  task automatic applyStimulus(input logic [3:0] cond, input logic [1:0] op,
                               input logic [5:0] funct, input logic [3:0] rd,
                               input logic [3:0] af);
    int   seq[$];
    logic ce;
    ctl_t e, m;
    Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = af;
    seq = '{FETCH, DECODE};
    case (op)
      2'b00: begin
        seq.push_back(funct[5] ? EXECI : EXECR);
        seq.push_back(ALUWB);
      end
      2'b01: begin
        seq.push_back(MEMADR);
        if (funct[0]) begin
          seq.push_back(MEMRD);
          seq.push_back(MEMWB);
        end else begin
          seq.push_back(MEMWR);
        end
      end
      2'b10:   seq.push_back(BRANCH);
      default: ;
    endcase
    foreach (seq[i]) begin
      @(negedge clk);
      ce = modelCond(cond, mflags);
      buildExp(seq[i], ce, funct, rd, 1'b0, e, m);
      checkOutput({stateName(seq[i]), ".state"}, {12'b0, StateDbg}, 16'(seq[i]));
      checkOutput({stateName(seq[i]), ".ctl"}, act & m, e & m);
      if ((seq[i] == EXECR || seq[i] == EXECI) && ce && (funct[0] || funct[4:1] == 4'b1010)) begin
        mflags[3:2] = af[3:2];
        if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010 || funct[4:1] == 4'b1010)
          mflags[1:0] = af[1:0];
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkReset(input string tag);
    ctl_t e, m;
    buildExp(FETCH, 1'b0, Funct, Rd, 1'b1, e, m);
    checkOutput({tag, ".state"}, {12'b0, StateDbg}, 16'(FETCH));
    checkOutput({tag, ".ctl"}, act & m, e & m);
  endtask

  // A branch under every condition code exposes all four stored flags.
  task automatic probeFlags();
    for (int c = 0; c < 16; c++)
      applyStimulus(4'(c), 2'b10, 6'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    reset = 1'b0; Cond = 4'h0; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; ALUFlags = 4'h0;
    mflags = 4'b0000;
    #2;
    checkReset("rst.init");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    probeFlags();

    applyStimulus(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0010);
    applyStimulus(4'hC, 2'b10, 6'b000000, 4'd0, 4'b0000);
    applyStimulus(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0010);
    applyStimulus(4'hB, 2'b10, 6'b000000, 4'd0, 4'b0000);

    applyStimulus(4'h0, 2'b00, 6'b001000, 4'd1, 4'b0100);
    applyStimulus(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
    applyStimulus(4'h0, 2'b00, 6'b001000, 4'd1, 4'b0000);

    applyStimulus(4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    applyStimulus(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);

    applyStimulus(4'hE, 2'b00, 6'b001001, 4'd2, 4'b1001);
    applyStimulus(4'hE, 2'b00, 6'b000001, 4'd2, 4'b0111);
    probeFlags();

    applyStimulus(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0110);
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("MEMADR.before_rst", {12'b0, StateDbg}, 16'(MEMADR));
    #2;
    reset = 1'b0;
    #1;
    checkReset("rst.mid");
    @(posedge clk); #1;
    checkReset("rst.hold");
    #1;
    reset = 1'b1;
    mflags = 4'b0000;
    probeFlags();

    for (int k = 0; k < 300; k++) begin
      logic [3:0] c, rd;
      c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      applyStimulus(c, 2'($urandom_range(0, 3)), 6'($urandom), rd, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
